// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage. Owns the fetch PC, requests words from
//            the instruction ROM over a req/ack handshake, buffers them in a
//            small FIFO and presents the head {pc, inst, valid} to decode.
//            A flush retargets fetch and discards buffered and in-flight
//            words. Decode sees pc=0/inst=0 (NOP) while the buffer is empty.
// Ports    :
//   clk, rst             clock, synchronous active-high reset
//   stall_i              decode cannot take the head instruction this cycle
//   flush_i, flush_pc_i  redirect fetch to flush_pc_i
//   rom_ce_o, rom_addr_o ROM request and byte address (word aligned)
//   rom_ack_i,rom_data_i ROM response (may coincide with the request cycle)
//   if_valid_o, if_pc_o, if_inst_o  head of the fetch buffer
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam int unsigned c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned c_cw = c_aw + 1;

    localparam logic [c_cw-1:0] c_depth   = FIFO_DEPTH[c_cw-1:0];
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    // DROP: a request was flushed while waiting; the handshake is kept
    // alive on the old address until the ROM answers, then discarded.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_addr;

    logic [31:0]      r_mem_pc   [FIFO_DEPTH];
    logic [31:0]      r_mem_inst [FIFO_DEPTH];
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_cw-1:0]  r_count;

    logic             w_pop;
    logic             w_push;
    logic [c_cw-1:0]  w_count_next;
    logic             w_has_space;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        w_pop        = (r_count != '0) && !stall_i && !flush_i;
        w_push       = (r_state == c_st_req) && rom_ack_i && !flush_i;
        // Occupancy after this cycle's push and pop; drives both the
        // IDLE->REQ decision and the stay-in-REQ decision.
        w_count_next = r_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
        w_has_space  = (w_count_next < c_depth);
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (!flush_i && w_has_space) begin
                    w_state_next = c_st_req;
                end
            end
            c_st_req: begin
                if (flush_i) begin
                    // An ack in the flush cycle closes the handshake, so
                    // nothing is left in flight to drop.
                    w_state_next = rom_ack_i ? c_st_idle : c_st_drop;
                end else if (rom_ack_i && !w_has_space) begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_drop: begin
                if (!flush_i && rom_ack_i) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch FSM, PC and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_fetch_pc <= RESET_PC & ~32'h3;
            r_req_addr <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_next;

            // Remember the address presented while in REQ so DROP can keep
            // driving it after a flush has already moved r_fetch_pc.
            if (r_state == c_st_req) begin
                r_req_addr <= r_fetch_pc;
            end

            if (flush_i) begin
                r_fetch_pc <= flush_pc_i & ~32'h3;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + c_ptr_one;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                r_count <= w_count_next;
            end
        end
    end

    // Buffer storage carries no reset; entries are only visible through
    // a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_inst[r_wr_ptr] <= rom_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all from registered state; no rom_* -> if_* path)
    // ------------------------------------------------------------------
    always_comb begin
        rom_ce_o   = (r_state == c_st_req) || (r_state == c_st_drop);
        rom_addr_o = '0;
        if (r_state == c_st_req) begin
            rom_addr_o = r_fetch_pc;
        end else if (r_state == c_st_drop) begin
            rom_addr_o = r_req_addr;
        end

        if_valid_o = (r_count != '0);
        if_pc_o    = if_valid_o ? r_mem_pc[r_rd_ptr]   : 32'h0;
        if_inst_o  = if_valid_o ? r_mem_inst[r_rd_ptr] : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch. A ROM responder with
//            configurable latency feeds the DUT; a stream scoreboard checks
//            every instruction decode consumes (expected PC sequence from
//            reset/flush targets, inst = rom contents at that PC). Directed
//            cycle tables and hand sequences cover latency, stall, flush,
//            drop and reset corners; a random phase mixes all of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        rom_ack_i;
    logic [31:0] rom_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .rom_ce_o   (rom_ce_o),
        .rom_addr_o (rom_addr_o),
        .rom_ack_i  (rom_ack_i),
        .rom_data_i (rom_data_i),
        .if_valid_o (if_valid_o),
        .if_pc_o    (if_pc_o),
        .if_inst_o  (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    logic [31:0] exp_pc;

    // ROM responder state
    logic        rom_manual;
    logic        rom_busy;
    int          rom_wait;
    int          rom_lat;
    int          rom_cur_lat;
    logic        rom_lat_rand;
    int          rom_idle_mode;   // ack while ce low: 0 never, 1 always, 2 random
    logic [31:0] rom_held;

    typedef struct {
        logic        stall;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic vec_t mk(input logic s, input logic ce, input logic [31:0] ad,
                                input logic v, input logic [31:0] pc);
        vec_t t;
        t.stall = s; t.exp_ce = ce; t.exp_addr = ad; t.exp_valid = v; t.exp_pc = pc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic rom_drive();
        logic [31:0] r;
        r = $urandom;
        if (rom_ce_o) begin
            if (!rom_busy) begin
                rom_busy    = 1'b1;
                rom_wait    = 0;
                rom_held    = rom_addr_o;
                rom_cur_lat = rom_lat_rand ? int'($urandom_range(0, 3)) : rom_lat;
            end else begin
                check("rom_addr_stable", rom_addr_o, rom_held);
            end
            if (rom_wait >= rom_cur_lat) begin
                rom_ack_i  = 1'b1;
                rom_data_i = rom_word(rom_addr_o);
                rom_busy   = 1'b0;
            end else begin
                rom_ack_i  = 1'b0;
                rom_data_i = r;
                rom_wait++;
            end
        end else begin
            rom_busy   = 1'b0;
            rom_data_i = r;
            case (rom_idle_mode)
                0:       rom_ack_i = 1'b0;
                1:       rom_ack_i = 1'b1;
                default: rom_ack_i = r[7];
            endcase
        end
    endtask

    // One clock cycle: apply decode-side inputs, answer the ROM, score any
    // instruction consumed at the coming edge, then move to the next sample
    // point (falling edge).
    task automatic cycle(input logic s, input logic f, input logic [31:0] fpc);
        stall_i    = s;
        flush_i    = f;
        flush_pc_i = fpc;
        if (!rom_manual) rom_drive();
        if (!if_valid_o) begin
            check("nop_pc", if_pc_o, 32'h0);
            check("nop_inst", if_inst_o, 32'h0);
        end
        if (rom_ce_o) check("addr_align", {30'h0, rom_addr_o[1:0]}, 32'h0);
        if (if_valid_o && !s && !f) begin
            check("pop_pc", if_pc_o, exp_pc);
            check("pop_inst", if_inst_o, rom_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (f) exp_pc = fpc & ~32'h3;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        flush_pc_i = 32'h0;
        rom_ack_i  = 1'b0;
        rom_data_i = 32'h0;
        rom_busy   = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RESET_PC;
        check("rst_ce", {31'h0, rom_ce_o}, 32'h0);
        check("rst_addr", rom_addr_o, 32'h0);
        check("rst_valid", {31'h0, if_valid_o}, 32'h0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_inst", if_inst_o, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rom_manual    = 1'b0;
        rom_busy      = 1'b0;
        rom_wait      = 0;
        rom_lat       = 0;
        rom_cur_lat   = 0;
        rom_lat_rand  = 1'b0;
        rom_idle_mode = 1;
        rom_held      = 32'h0;
        exp_pc        = RESET_PC;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
        rom_ack_i = 1'b0; rom_data_i = 32'h0;
        @(negedge clk);

        // ---- ack tied high, zero wait; 5-cycle stall fills the buffer ----
        tbl[0]  = mk(1'b0, 1'b0, 32'h00, 1'b0, 32'h00);
        tbl[1]  = mk(1'b0, 1'b1, 32'h00, 1'b0, 32'h00);
        tbl[2]  = mk(1'b0, 1'b1, 32'h04, 1'b1, 32'h00);
        tbl[3]  = mk(1'b0, 1'b1, 32'h08, 1'b1, 32'h04);
        tbl[4]  = mk(1'b1, 1'b1, 32'h0C, 1'b1, 32'h08);
        tbl[5]  = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[6]  = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[7]  = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[8]  = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[9]  = mk(1'b0, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[10] = mk(1'b0, 1'b1, 32'h10, 1'b1, 32'h0C);
        tbl[11] = mk(1'b0, 1'b1, 32'h14, 1'b1, 32'h10);
        tbl[12] = mk(1'b0, 1'b1, 32'h18, 1'b1, 32'h14);
        rom_lat = 0; rom_idle_mode = 1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            check("tbl_ce", {31'h0, rom_ce_o}, {31'h0, tbl[i].exp_ce});
            check("tbl_addr", rom_addr_o, tbl[i].exp_addr);
            check("tbl_valid", {31'h0, if_valid_o}, {31'h0, tbl[i].exp_valid});
            check("tbl_pc", if_pc_o, tbl[i].exp_pc);
            check("tbl_inst", if_inst_o, tbl[i].exp_valid ? rom_word(tbl[i].exp_pc) : 32'h0);
            cycle(tbl[i].stall, 1'b0, 32'h0);
        end

        // ---- ROM answers 3 cycles after ce: one instruction per 4 cycles ----
        rom_lat = 3; rom_idle_mode = 0;
        do_reset();
        for (int c = 0; c < 41; c++) begin
            logic ev;
            ev = (c >= 5) && (((c - 5) % 4) == 0);
            check("lat3_valid", {31'h0, if_valid_o}, {31'h0, ev});
            check("lat3_ce", {31'h0, rom_ce_o}, {31'h0, (c >= 1)});
            if (ev) check("lat3_pc", if_pc_o, 32'((c - 5) / 4 * 4));
            cycle(1'b0, 1'b0, 32'h0);
        end

        // ---- flush while waiting -> DROP on old address, refetch at target ----
        rom_manual = 1'b1;
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        check("drop_req_ce", {31'h0, rom_ce_o}, 32'h1);
        check("drop_req_addr", rom_addr_o, 32'h0);
        cycle(1'b0, 1'b1, 32'h100);
        check("drop_ce", {31'h0, rom_ce_o}, 32'h1);
        check("drop_addr", rom_addr_o, 32'h0);
        cycle(1'b0, 1'b1, 32'h180);           // second flush while dropping
        check("drop2_ce", {31'h0, rom_ce_o}, 32'h1);
        check("drop2_addr", rom_addr_o, 32'h0);
        rom_ack_i = 1'b1; rom_data_i = 32'hBAD0_BAD0;
        cycle(1'b0, 1'b0, 32'h0);
        check("drop_done_ce", {31'h0, rom_ce_o}, 32'h0);
        check("drop_done_valid", {31'h0, if_valid_o}, 32'h0);
        rom_ack_i = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        check("refetch_ce", {31'h0, rom_ce_o}, 32'h1);
        check("refetch_addr", rom_addr_o, 32'h180);
        rom_ack_i = 1'b1; rom_data_i = rom_word(32'h180);
        cycle(1'b0, 1'b0, 32'h0);
        check("refetch_valid", {31'h0, if_valid_o}, 32'h1);
        check("refetch_pc", if_pc_o, 32'h180);
        rom_ack_i = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);

        // ---- flush with ack, buffer full and stalled; then flush on REQ+ack ----
        rom_manual = 1'b0; rom_lat = 0; rom_idle_mode = 1;
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("full_ce", {31'h0, rom_ce_o}, 32'h0);
        check("full_pc", if_pc_o, 32'h0);
        cycle(1'b1, 1'b1, 32'h200);
        check("fl_full_valid", {31'h0, if_valid_o}, 32'h0);
        check("fl_full_ce", {31'h0, rom_ce_o}, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("fl_resume_addr", rom_addr_o, 32'h200);
        cycle(1'b1, 1'b1, 32'h300);           // ack lands in the flush cycle
        check("fl_ack_valid", {31'h0, if_valid_o}, 32'h0);
        check("fl_ack_ce", {31'h0, rom_ce_o}, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("fl_ack_addr", rom_addr_o, 32'h300);
        cycle(1'b1, 1'b0, 32'h0);
        check("fl_ack_pc", if_pc_o, 32'h300);
        cycle(1'b0, 1'b0, 32'h0);

        // ---- reset while a request is pending; late ack must be ignored ----
        rom_idle_mode = 0;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        rom_manual = 1'b1; rom_ack_i = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        check("pend_ce", {31'h0, rom_ce_o}, 32'h1);
        check("pend_addr", rom_addr_o, 32'h0C);
        do_reset();
        rom_ack_i = 1'b1; rom_data_i = 32'hDEAD_BEEF;
        cycle(1'b0, 1'b0, 32'h0);
        check("late_ack_valid", {31'h0, if_valid_o}, 32'h0);
        check("late_ack_addr", rom_addr_o, RESET_PC);
        rom_ack_i = 1'b1; rom_data_i = rom_word(RESET_PC);
        cycle(1'b0, 1'b0, 32'h0);
        check("post_rst_pc", if_pc_o, RESET_PC);
        rom_ack_i = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);

        // ---- random mix: latency 0..3, stalls, flushes, stray acks, resets ----
        rom_manual = 1'b0; rom_lat_rand = 1'b1; rom_idle_mode = 2;
        n_pops = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [31:0] fpc;
            logic        s;
            logic        f;
            r   = $urandom;
            s   = ($urandom_range(0, 9) < 3);
            f   = ($urandom_range(0, 49) == 0);
            fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {r[31:2], 2'b00};
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle(s, f, fpc);
            end
        end
        check("liveness", {31'h0, (n_pops > 300)}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
